// File: rtl/evt_mon_pkg.sv
// evt_mon_pkg
// Shared definitions for the event-monitor register block and its drain master:
// register addresses, CONTROL/STATUS bit positions, the drain-FSM state encoding
// and a helper that assembles a CONTROL write word.
package evt_mon_pkg;

    // Register map (byte addresses on the 8-bit monitor bus)
    localparam logic [7:0] ADDR_CONTROL    = 8'h00;
    localparam logic [7:0] ADDR_TRIG_VALUE = 8'h04;
    localparam logic [7:0] ADDR_TRIG_MASK  = 8'h08;
    localparam logic [7:0] ADDR_STATUS     = 8'h0C;
    localparam logic [7:0] ADDR_EVT_LO     = 8'h10;
    localparam logic [7:0] ADDR_EVT_MID    = 8'h14;
    localparam logic [7:0] ADDR_EVT_HI     = 8'h18;  // reading this pops the event FIFO

    // CONTROL bit indices
    localparam int unsigned CTRL_EN   = 32'd0;
    localparam int unsigned CTRL_ARM  = 32'd1;
    localparam int unsigned CTRL_MODE = 32'd2;
    localparam int unsigned CTRL_CLR  = 32'd3;

    // STATUS bit indices
    localparam int unsigned STAT_EMPTY  = 32'd0;
    localparam int unsigned STAT_FULL   = 32'd1;
    localparam int unsigned STAT_CNT_LO = 32'd8;
    localparam int unsigned STAT_CNT_HI = 32'd15;
    localparam int unsigned STAT_TRIG   = 32'd16;
    localparam int unsigned STAT_OVF    = 32'd17;

    // Drain FSM states
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_VAL  = 4'd1,
        ST_WR_MASK = 4'd2,
        ST_WR_CLR  = 4'd3,
        ST_WR_CTRL = 4'd4,
        ST_POLL    = 4'd5,
        ST_WAIT    = 4'd6,
        ST_RD_LO   = 4'd7,
        ST_RD_MID  = 4'd8,
        ST_RD_HI   = 4'd9,
        ST_EMIT    = 4'd10,
        ST_WR_STOP = 4'd11
    } drain_state_e;

    // Assemble a CONTROL register value from its individual fields
    function automatic logic [31:0] ctrl_word(input logic en, input logic arm,
                                              input logic mode, input logic clr);
        logic [31:0] w;
        w            = 32'd0;
        w[CTRL_EN]   = en;
        w[CTRL_ARM]  = arm;
        w[CTRL_MODE] = mode;
        w[CTRL_CLR]  = clr;
        return w;
    endfunction

endpackage

// File: rtl/evt_drain_master.sv
// evt_drain_master
// Bus initiator for the event-monitor register block. On cfg_start it programs
// trigger value/mask, clears the monitor stickies, then enables and arms it. It
// then polls STATUS; each captured event is drained with three reads (the last
// pops the monitor FIFO) and re-emitted downstream as one valid/ready word.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_start/cfg_stop          start pulse (ignored while busy), stop request
//   cfg_trig_value/mask/mode    trigger setup, sampled at cfg_start
//   bus_wr/rd/addr/wdata/rdata  monitor register bus (rdata combinational)
//   out_valid/ready/data        event stream, data = {ts, id, probe}
//   busy, triggered_seen, overflow_seen, evt_count   status outputs
module evt_drain_master
    import evt_mon_pkg::*;
#(
    parameter int PROBE_W       = 32,
    parameter int ID_W          = 8,
    parameter int TS_W          = 32,
    parameter int POLL_INTERVAL = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic                         cfg_stop,
    input  logic [PROBE_W-1:0]           cfg_trig_value,
    input  logic [PROBE_W-1:0]           cfg_trig_mask,
    input  logic                         cfg_trig_mode,
    output logic                         bus_wr,
    output logic                         bus_rd,
    output logic [7:0]                   bus_addr,
    output logic [31:0]                  bus_wdata,
    input  logic [31:0]                  bus_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TS_W+ID_W+PROBE_W-1:0] out_data,
    output logic                         busy,
    output logic                         triggered_seen,
    output logic                         overflow_seen,
    output logic [15:0]                  evt_count
);

    localparam int TMR_W = $clog2(POLL_INTERVAL + 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_INTERVAL - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(32'd1);
    localparam logic [TMR_W-1:0] TMR_ZERO   = TMR_W'(32'd0);

    drain_state_e        state_q, state_d;
    logic                stop_q, stop_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [PROBE_W-1:0]  mask_q, mask_d;
    logic                mode_q, mode_d;
    logic [PROBE_W-1:0]  probe_q, probe_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic                trig_q, trig_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                bus_wr_q, bus_wr_d;
    logic                bus_rd_q, bus_rd_d;
    logic [7:0]          bus_addr_q, bus_addr_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    // Next-state, capture and sticky logic for the drain FSM
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        probe_d = probe_q;
        id_d    = id_q;
        ts_d    = ts_q;
        trig_d  = trig_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        // A stop that coincides with a start in IDLE stays pending for the new run
        if (cfg_stop) begin
            stop_d = 1'b1;
        end else if (state_q == ST_WR_STOP) begin
            stop_d = 1'b0;
        end else if ((state_q == ST_IDLE) && cfg_start) begin
            stop_d = 1'b0;
        end else begin
            stop_d = stop_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_WR_VAL;
                    mask_d  = cfg_trig_mask;
                    mode_d  = cfg_trig_mode;
                    trig_d  = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_VAL:  state_d = ST_WR_MASK;
            ST_WR_MASK: state_d = ST_WR_CLR;
            ST_WR_CLR:  state_d = ST_WR_CTRL;
            ST_WR_CTRL: state_d = ST_POLL;
            ST_POLL: begin
                trig_d = trig_q | bus_rdata[STAT_TRIG];
                ovf_d  = ovf_q | bus_rdata[STAT_OVF];
                if (stop_q) begin
                    state_d = ST_WR_STOP;
                end else if (!bus_rdata[STAT_EMPTY]) begin
                    state_d = ST_RD_LO;
                end else begin
                    state_d = ST_WAIT;
                    tmr_d   = TMR_RELOAD;
                end
            end
            ST_WAIT: begin
                if (stop_q) begin
                    state_d = ST_WR_STOP;
                end else if (tmr_q == TMR_ZERO) begin
                    state_d = ST_POLL;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_RD_LO: begin
                probe_d = bus_rdata[PROBE_W-1:0];
                state_d = ST_RD_MID;
            end
            ST_RD_MID: begin
                id_d       = bus_rdata[ID_W-1:0];
                ts_d[23:0] = bus_rdata[31:8];
                state_d    = ST_RD_HI;
            end
            ST_RD_HI: begin
                ts_d[TS_W-1:24] = bus_rdata[7:0];
                state_d         = ST_EMIT;
            end
            ST_EMIT: begin
                // Back to POLL directly: a pending stop is honoured there
                if (out_ready) begin
                    state_d = ST_POLL;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_WR_STOP: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus and stream outputs are decoded from the next state so they register
    // into the same cycle the FSM occupies that state
    always_comb begin
        bus_wr_d    = 1'b0;
        bus_rd_d    = 1'b0;
        bus_addr_d  = 8'h00;
        bus_wdata_d = 32'd0;
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_EMIT);
        case (state_d)
            ST_WR_VAL: begin
                // Only entered from IDLE on cfg_start, so the live input is the sample
                bus_wr_d    = 1'b1;
                bus_addr_d  = ADDR_TRIG_VALUE;
                bus_wdata_d = 32'(cfg_trig_value);
            end
            ST_WR_MASK: begin
                bus_wr_d    = 1'b1;
                bus_addr_d  = ADDR_TRIG_MASK;
                bus_wdata_d = 32'(mask_q);
            end
            ST_WR_CLR: begin
                bus_wr_d    = 1'b1;
                bus_addr_d  = ADDR_CONTROL;
                bus_wdata_d = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
            end
            ST_WR_CTRL: begin
                bus_wr_d    = 1'b1;
                bus_addr_d  = ADDR_CONTROL;
                bus_wdata_d = ctrl_word(1'b1, 1'b1, mode_q, 1'b0);
            end
            ST_WR_STOP: begin
                bus_wr_d    = 1'b1;
                bus_addr_d  = ADDR_CONTROL;
                bus_wdata_d = 32'd0;
            end
            ST_POLL: begin
                bus_rd_d   = 1'b1;
                bus_addr_d = ADDR_STATUS;
            end
            ST_RD_LO: begin
                bus_rd_d   = 1'b1;
                bus_addr_d = ADDR_EVT_LO;
            end
            ST_RD_MID: begin
                bus_rd_d   = 1'b1;
                bus_addr_d = ADDR_EVT_MID;
            end
            ST_RD_HI: begin
                bus_rd_d   = 1'b1;
                bus_addr_d = ADDR_EVT_HI;
            end
            default: begin
                bus_wr_d = 1'b0;
                bus_rd_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stop_q      <= 1'b0;
            tmr_q       <= TMR_ZERO;
            mask_q      <= '0;
            mode_q      <= 1'b0;
            probe_q     <= '0;
            id_q        <= '0;
            ts_q        <= '0;
            trig_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= 16'd0;
            bus_wr_q    <= 1'b0;
            bus_rd_q    <= 1'b0;
            bus_addr_q  <= 8'h00;
            bus_wdata_q <= 32'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_q      <= stop_d;
            tmr_q       <= tmr_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            probe_q     <= probe_d;
            id_q        <= id_d;
            ts_q        <= ts_d;
            trig_q      <= trig_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            bus_wr_q    <= bus_wr_d;
            bus_rd_q    <= bus_rd_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus_wr         = bus_wr_q;
    assign bus_rd         = bus_rd_q;
    assign bus_addr       = bus_addr_q;
    assign bus_wdata      = bus_wdata_q;
    assign out_valid      = out_valid_q;
    assign out_data       = {ts_q, id_q, probe_q};
    assign busy           = busy_q;
    assign triggered_seen = trig_q;
    assign overflow_seen  = ovf_q;
    assign evt_count      = cnt_q;

endmodule

// File: tb/tb_evt_drain_master.sv
// tb_evt_drain_master
// Directed bench for evt_drain_master with a small behavioural model of the
// event-monitor register block acting as bus responder.
module tb_evt_drain_master;
    import evt_mon_pkg::*;

    localparam int PROBE_W = 32;
    localparam int ID_W    = 8;
    localparam int TS_W    = 32;
    localparam int OUT_W   = TS_W + ID_W + PROBE_W;
    localparam int LOG_N   = 1024;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_start = 1'b0;
    logic               cfg_stop = 1'b0;
    logic [PROBE_W-1:0] cfg_trig_value = '0;
    logic [PROBE_W-1:0] cfg_trig_mask = '0;
    logic               cfg_trig_mode = 1'b0;
    logic               bus_wr, bus_rd;
    logic [7:0]         bus_addr;
    logic [31:0]        bus_wdata, bus_rdata;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OUT_W-1:0]   out_data;
    logic               busy, triggered_seen, overflow_seen;
    logic [15:0]        evt_count;

    evt_drain_master #(.PROBE_W(PROBE_W), .ID_W(ID_W), .TS_W(TS_W), .POLL_INTERVAL(16)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_trig_value(cfg_trig_value), .cfg_trig_mask(cfg_trig_mask), .cfg_trig_mode(cfg_trig_mode),
        .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .triggered_seen(triggered_seen), .overflow_seen(overflow_seen),
        .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    // ---------------- monitor register block model ----------------
    logic [95:0] fifo_mem [0:15];   // {hi, mid, lo} raw register words
    int          wp = 0;            // written by the stimulus only
    int          rp = 0;            // written by the clocked responder only
    logic        trig_f = 1'b0, ovf_f = 1'b0;
    logic [31:0] status_s;
    logic [95:0] head_s;

    always_comb begin
        head_s                 = fifo_mem[rp[3:0]];
        status_s               = 32'd0;
        status_s[STAT_EMPTY]   = (wp == rp);
        status_s[STAT_FULL]    = ((wp - rp) >= 16);
        status_s[STAT_CNT_HI:STAT_CNT_LO] = 8'(wp - rp);
        status_s[STAT_TRIG]    = trig_f;
        status_s[STAT_OVF]     = ovf_f;
        case (bus_addr)
            ADDR_STATUS:  bus_rdata = status_s;
            ADDR_EVT_LO:  bus_rdata = head_s[31:0];
            ADDR_EVT_MID: bus_rdata = head_s[63:32];
            ADDR_EVT_HI:  bus_rdata = head_s[95:64];
            default:      bus_rdata = 32'd0;
        endcase
    end

    // ---------------- access log and protocol watch ----------------
    int          cyc = 0;
    int          acc_n = 0;
    int          rd18_n = 0;
    int          viol = 0;
    logic [7:0]  acc_addr [0:LOG_N-1];
    logic        acc_wr   [0:LOG_N-1];
    logic [31:0] acc_data [0:LOG_N-1];
    int          acc_cyc  [0:LOG_N-1];

    always @(posedge clk) begin
        if (bus_rd === 1'b1 && bus_addr == ADDR_EVT_HI) begin
            rd18_n <= rd18_n + 1;
            if (wp != rp) rp <= rp + 1;
        end
        if (bus_wr === 1'b1 || bus_rd === 1'b1) begin
            if (acc_n < LOG_N) begin
                acc_addr[acc_n] <= bus_addr;
                acc_wr[acc_n]   <= bus_wr;
                acc_data[acc_n] <= bus_wdata;
                acc_cyc[acc_n]  <= cyc;
            end
            acc_n <= acc_n + 1;
        end
        if ((bus_wr === 1'b1 && bus_rd === 1'b1) ||
            (bus_wr === 1'b0 && bus_rd === 1'b0 && (bus_addr !== 8'h00 || bus_wdata !== 32'd0)) ||
            (out_valid === 1'b1 && (bus_wr === 1'b1 || bus_rd === 1'b1)))
            viol <= viol + 1;
        cyc <= cyc + 1;
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_evt(input logic [31:0] lo, input logic [31:0] mid, input logic [31:0] hi);
        fifo_mem[wp[3:0]] = {hi, mid, lo};
        wp = wp + 1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (out_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_rd(input logic [7:0] addr, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus_rd === 1'b1 && bus_addr == addr) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        int          dt;
    } acc_vec_t;

    typedef struct {
        logic [31:0]      lo, mid, hi;
        logic [OUT_W-1:0] exp;
    } evt_vec_t;

    acc_vec_t wseq [0:4];
    evt_vec_t evs  [0:2];

    initial begin
        int base, nacc, rd_base, t_start, t_valid, b;
        bit ok;

        // start-up access sequence for value=0xA5, mask=0xFF, mode=1
        wseq[0] = '{ADDR_TRIG_VALUE, 1'b1, 32'h0000_00A5, 1};
        wseq[1] = '{ADDR_TRIG_MASK,  1'b1, 32'h0000_00FF, 2};
        wseq[2] = '{ADDR_CONTROL,    1'b1, 32'h0000_0008, 3};
        wseq[3] = '{ADDR_CONTROL,    1'b1, 32'h0000_0007, 4};
        wseq[4] = '{ADDR_STATUS,     1'b0, 32'h0000_0000, 5};
        // raw {lo, mid, hi} register words and the packed {ts, id, probe} they must give
        evs[0] = '{32'hDEADBEEF, 32'h3456783C, 32'hABCDEF12, 72'h12345678_3C_DEADBEEF};
        evs[1] = '{32'h00000001, 32'hFFFFFF00, 32'h000000FF, 72'hFFFFFFFF_00_00000001};
        evs[2] = '{32'h80000000, 32'h000001A5, 32'hFFFFFF00, 72'h00000001_A5_80000000};

        // reset state
        tick(3);
        chk("reset_ctl", {bus_wr, bus_rd, bus_addr, bus_wdata, out_valid, busy,
                          triggered_seen, overflow_seen, evt_count}, 128'd0);
        chk("reset_data", out_data, 128'd0);
        rst = 1'b0;
        tick(2);

        // programming sequence
        base = acc_n; t_start = cyc;
        cfg_trig_value = 32'h0000_00A5; cfg_trig_mask = 32'h0000_00FF; cfg_trig_mode = 1'b1;
        cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
        tick(5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("prog_acc%0d", i),
                {acc_addr[base+i], acc_wr[base+i], acc_data[base+i], 16'(acc_cyc[base+i] - t_start)},
                {wseq[i].addr, wseq[i].wr, wseq[i].wdata, 16'(wseq[i].dt)});
        chk("busy_running", busy, 1'b1);

        // empty FIFO: poll spacing
        tick(40);
        chk("poll_gap1", {acc_addr[base+5], acc_wr[base+5], 16'(acc_cyc[base+5] - acc_cyc[base+4])},
            {ADDR_STATUS, 1'b0, 16'd17});
        chk("poll_gap2", {acc_addr[base+6], acc_wr[base+6], 16'(acc_cyc[base+6] - acc_cyc[base+5])},
            {ADDR_STATUS, 1'b0, 16'd17});
        chk("flags_clear", {triggered_seen, overflow_seen}, 2'b00);

        // event drain table; first event also held under backpressure
        rd_base = rd18_n;
        for (int i = 0; i < 3; i++) begin
            base = acc_n;
            push_evt(evs[i].lo, evs[i].mid, evs[i].hi);
            wait_valid(ok);
            t_valid = cyc;
            chk($sformatf("evt%0d_valid", i), ok, 1'b1);
            chk($sformatf("evt%0d_data", i), out_data, evs[i].exp);
            chk($sformatf("evt%0d_seq", i),
                {acc_addr[base], acc_addr[base+1], acc_addr[base+2], acc_addr[base+3],
                 8'(acc_cyc[base+1] - acc_cyc[base]), 8'(acc_cyc[base+2] - acc_cyc[base]),
                 8'(acc_cyc[base+3] - acc_cyc[base]), 8'(t_valid - acc_cyc[base])},
                {ADDR_STATUS, ADDR_EVT_LO, ADDR_EVT_MID, ADDR_EVT_HI, 8'd1, 8'd2, 8'd3, 8'd4});
            if (i == 0) begin
                nacc = acc_n;
                for (int k = 0; k < 10; k++) begin
                    tick(1);
                    chk($sformatf("bp_hold%0d", k), {out_valid, out_data}, {1'b1, evs[0].exp});
                end
                chk("bp_no_bus", 16'(acc_n - nacc), 16'd0);
            end
            out_ready = 1'b1; tick(1); out_ready = 1'b0;
            chk($sformatf("evt%0d_accepted", i), {out_valid, evt_count}, {1'b0, 16'(i + 1)});
        end
        chk("one_pop_per_event", 16'(rd18_n - rd_base), 16'd3);

        // STATUS = 0x00030001: both stickies must be picked up
        trig_f = 1'b1; ovf_f = 1'b1;
        tick(20);
        chk("status_flags", {triggered_seen, overflow_seen}, 2'b11);
        trig_f = 1'b0; ovf_f = 1'b0;

        // stop request arriving during RD_MID
        push_evt(evs[1].lo, evs[1].mid, evs[1].hi);
        wait_rd(ADDR_EVT_MID, ok);
        chk("stop_reach_mid", ok, 1'b1);
        cfg_stop = 1'b1; tick(1); cfg_stop = 1'b0;
        wait_valid(ok);
        chk("stop_evt_data", {ok, out_data}, {1'b1, evs[1].exp});
        nacc = acc_n;
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        tick(2);
        chk("stop_poll", {acc_addr[nacc], acc_wr[nacc]}, {ADDR_STATUS, 1'b0});
        chk("stop_write", {acc_addr[nacc+1], acc_wr[nacc+1], acc_data[nacc+1],
                           8'(acc_cyc[nacc+1] - acc_cyc[nacc])}, {ADDR_CONTROL, 1'b1, 32'd0, 8'd1});
        chk("stop_idle", {busy, evt_count}, {1'b0, 16'd4});
        tick(20);
        chk("stop_quiet", 16'(acc_n - nacc), 16'd2);

        // start and stop in the same cycle: full program, one poll, then stop write
        base = acc_n; t_start = cyc;
        cfg_start = 1'b1; cfg_stop = 1'b1; tick(1); cfg_start = 1'b0; cfg_stop = 1'b0;
        tick(8);
        b = base + 5;
        chk("startstop_count", 16'(acc_n - base), 16'd6);
        chk("startstop_stop", {acc_addr[b], acc_wr[b], acc_data[b], 8'(acc_cyc[b] - t_start)},
            {ADDR_CONTROL, 1'b1, 32'd0, 8'd6});
        chk("startstop_idle", {busy, evt_count, triggered_seen, overflow_seen}, {1'b0, 16'd0, 2'b00});

        // reset in the middle of an event read
        trig_f = 1'b1;
        push_evt(evs[2].lo, evs[2].mid, evs[2].hi);
        cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
        wait_rd(ADDR_EVT_LO, ok);
        chk("rst_reach_lo", {ok, triggered_seen}, 2'b11);
        rst = 1'b1; tick(1);
        chk("rst_mid_ctl", {bus_wr, bus_rd, bus_addr, bus_wdata, out_valid, busy,
                            triggered_seen, overflow_seen, evt_count}, 128'd0);
        chk("rst_mid_data", out_data, 128'd0);
        rst = 1'b0; trig_f = 1'b0;
        nacc = acc_n;
        tick(5);
        chk("rst_stays_idle", {busy, 16'(acc_n - nacc)}, {1'b0, 16'd0});

        chk("bus_protocol", viol, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
